alu_uart_interface: RTL
=======================

Name: alu_uart_interface

Overview:
- Frame sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU and captures the ALU result.
- Hands the result byte to the UART transmitter with a start/done handshake.
- Includes opcode validation, a partial-frame watchdog and overrun flagging.

Parameters:
- NB_DATA, 8, width of operands, result, and RX/TX bytes.
- NB_OP, 6, width of the ALU opcode.
- TIMEOUT_CYCLES, 1000000, idle clock cycles allowed between bytes of one frame before resync.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  byte from the UART receiver; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse marking a received byte.
- o_data_a  out  NB_DATA  registered operand A to the ALU.
- o_data_b  out  NB_DATA  registered operand B to the ALU.
- o_op  out  NB_OP  registered opcode to the ALU.
- i_alu_result  in  NB_DATA  combinational ALU result.
- o_tx_data  out  NB_DATA  registered result byte to the UART transmitter.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- i_tx_done  in  1  one-cycle pulse from the transmitter when the byte has been sent.
- o_op_error  out  1  one-cycle pulse: invalid opcode received, frame discarded.
- o_overrun  out  1  one-cycle pulse: byte arrived while result not yet sent; byte dropped.

Behaviour:
- Reset: i_reset asserted forces state IDLE immediately (asynchronous). All outputs are 0 and the timeout counter is 0. Reset mid-frame discards all partial data.
- States: IDLE, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- IDLE: on i_rx_done, o_data_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done:
  - Valid opcode: o_op <= i_rx_data[NB_OP-1:0], go to EXEC.
  - Invalid opcode: o_op_error=1 for one cycle, o_op unchanged, go to IDLE.
- Valid opcodes: upper NB_DATA-NB_OP bits of the byte are 0, and the low bits are one of 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x03 sra, 0x02 srl, 0x27 nor.
- EXEC (exactly one cycle): o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
- WAIT_TX: o_tx_start is 0 after its single cycle. On i_tx_done, go to IDLE.
- Latency: if the opcode byte is sampled at edge E0, o_tx_start is high from E1 to E2 and o_tx_data is stable from E1 until the next frame's EXEC.
- o_data_a, o_data_b and o_op hold their values until overwritten. No bus is cleared between frames.
- Overrun: i_rx_done in EXEC or WAIT_TX gives o_overrun=1 for one cycle. The byte is ignored and the state is unchanged.
- Simultaneous i_tx_done and i_rx_done in WAIT_TX: the overrun is flagged, the byte is dropped, and the state goes to IDLE. The next byte starts a new frame.
- Watchdog:
  - The counter runs only in WAIT_B and WAIT_OP. It clears on every i_rx_done and on entry to those states.
  - When the counter reaches TIMEOUT_CYCLES-1 without a byte, the next edge forces IDLE and discards the partial frame. No error pulse is generated.
  - If i_rx_done arrives on the same cycle as the expiry, the byte wins: it is accepted and the counter clears.
- Counter width: $clog2(TIMEOUT_CYCLES)+1; saturation is not required.
- Arithmetic: none inside the block. The result is the ALU's NB_DATA-bit output, taken unmodified.
- i_tx_done outside WAIT_TX: ignored.

Test Plan:
- Bytes 0x05, 0x03, 0x20 -> o_op=0x20, one o_tx_start pulse two edges after the op byte, o_tx_data=0x08; after i_tx_done the state returns to IDLE.
- Bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE. Then bytes 0x80, 0x01, 0x03 -> o_tx_data=0xC0 (sra). Back-to-back frames need no extra idle cycles.
- Bytes 0x0F, 0xF0, 0x21 -> o_op_error pulse, no o_tx_start, o_op keeps its prior value. Then 0x0F, 0xF0, 0x25 -> o_tx_data=0xFF. Byte 0x60 as opcode is also rejected.
- TIMEOUT_CYCLES=16; byte 0xAA, then 20 idle cycles -> state IDLE. Then 0x01, 0x02, 0x20 -> o_tx_data=0x03 (0xAA is not used).
- Valid frame, then i_rx_done with 0x77 while in WAIT_TX -> o_overrun pulse, o_tx_data unchanged. The next frame after i_tx_done computes normally.
- i_reset asserted mid-cycle after operand B -> all outputs 0 without waiting for a clock edge. After release, bytes 0x02, 0x03, 0x24 -> o_tx_data=0x02.

Source files
------------

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: frame sequencer between a UART RX/TX pair and a
// combinational ALU. Collects operand A, operand B and opcode bytes, drives
// them to the ALU and hands the captured result to the UART transmitter.
//
// Handshakes: i_rx_done and i_tx_done are single-cycle pulses. A byte is
// consumed only on a cycle where i_rx_done=1. o_tx_start is a single-cycle
// request, and the transmitter answers it with i_tx_done. o_op_error and
// o_overrun are single-cycle event flags.
module alu_uart_interface #(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_op_error,
   output logic               o_overrun
);

   localparam int NB_CNT = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(8'h20);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(8'h22);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(8'h24);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(8'h25);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(8'h26);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(8'h03);
   localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(8'h02);
   localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(8'h27);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   state_t              r_state;
   logic [NB_CNT-1:0]   r_cnt;
   logic [NB_DATA-1:0]  r_data_a;
   logic [NB_DATA-1:0]  r_data_b;
   logic [NB_OP-1:0]    r_op;
   logic [NB_DATA-1:0]  r_tx_data;
   logic                r_tx_start;
   logic                r_op_error;
   logic                r_overrun;

   logic [NB_OP-1:0]    w_op_bits;
   logic                w_op_valid;
   logic                w_timeout;

   // Opcode byte is accepted only if its upper bits are clear and the low
   // bits name one of the supported ALU operations.
   always_comb begin
      w_op_bits  = i_rx_data[NB_OP-1:0];
      w_op_valid = (i_rx_data[NB_DATA-1:NB_OP] == '0) &&
                   (w_op_bits inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                      OP_XOR, OP_SRA, OP_SRL, OP_NOR});
      w_timeout  = (r_cnt == CNT_LAST);
   end

   // Frame sequencer; a received byte always takes priority over watchdog expiry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_data_a   <= '0;
         r_data_b   <= '0;
         r_op       <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_op_error <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_op_error <= 1'b0;
         r_overrun  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (i_rx_done) begin
                  r_data_a <= i_rx_data;
                  r_state  <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (i_rx_done) begin
                  r_data_b <= i_rx_data;
                  r_cnt    <= '0;
                  r_state  <= WAIT_OP;
               end else if (w_timeout) begin
                  r_cnt    <= '0;
                  r_state  <= IDLE;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
               end
            end
            WAIT_OP: begin
               if (i_rx_done) begin
                  r_cnt <= '0;
                  if (w_op_valid) begin
                     r_op    <= w_op_bits;
                     r_state <= EXEC;
                  end else begin
                     r_op_error <= 1'b1;
                     r_state    <= IDLE;
                  end
               end else if (w_timeout) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            EXEC: begin
               r_tx_data  <= i_alu_result;
               r_tx_start <= 1'b1;
               r_state    <= WAIT_TX;
               if (i_rx_done) r_overrun <= 1'b1;
            end
            WAIT_TX: begin
               if (i_rx_done) r_overrun <= 1'b1;
               if (i_tx_done) r_state <= IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_data_a   = r_data_a;
   assign o_data_b   = r_data_b;
   assign o_op       = r_op;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = r_tx_start;
   assign o_op_error = r_op_error;
   assign o_overrun  = r_overrun;

endmodule
